stream_check_sink: RTL

- Parametrised successor of the stream sink used by the network test harnesses.
- Terminates an AM-side valid/ready stream of LANES packed signed samples and compares every accepted word lane-by-lane against a preloaded expected-value table, with a per-lane absolute tolerance.
- Provides a configurable backpressure pattern and an idle-cycle timeout, and reports pass/fail, error count and first failing index.
- Sits at the output of Network (or any layer) in self-checking benches and in on-chip BIST wrappers.

---
 rtl/stream_check_sink.sv | 134 +++++++++++++
 1 files changed

// File: rtl/stream_check_sink.sv
// rtl/stream_check_sink.sv - valid/ready sink comparing accepted words against an expected-value table
module stream_check_sink #(
    parameter int    SIZE         = 10,
    parameter int    WIDTH        = 8,
    parameter int    LANES        = 1,
    // Expected words, word i at bits [i*LANES*WIDTH +: LANES*WIDTH]
    parameter logic [SIZE*LANES*WIDTH-1:0] EXPECT_INIT = '0,
    parameter string BURST        = "yes",
    parameter int    STALL_PERIOD = 3,
    parameter int    TOLERANCE    = 0,
    parameter int    TIMEOUT      = 1000,
    localparam int   CW           = $clog2(SIZE + 1)
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iValid_AM,
    output logic                   oReady_AM,
    input  logic [LANES*WIDTH-1:0] iData_AM,
    output logic                   oDone,
    output logic                   oPass,
    output logic                   oTimeout,
    output logic [CW-1:0]          oCount,
    output logic [CW-1:0]          oErrCount,
    output logic [CW-1:0]          oFirstErr
);

    localparam int DW       = LANES * WIDTH;
    localparam int SW       = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam int TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit THROTTLE = (BURST == "no");
    localparam logic [CW-1:0] NONE = '1;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_DONE = 2'd1;
    localparam logic [1:0] S_TOUT = 2'd2;

    logic [1:0]    r_state;
    logic          r_ready;
    logic          r_done;
    logic          r_pass;
    logic          r_tout;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_err;
    logic [CW-1:0] r_first;
    logic [SW-1:0] r_stall;
    logic [TW-1:0] r_idle;

    logic [DW-1:0]    w_exp;
    logic [LANES-1:0] w_lane_bad;
    logic             w_word_bad;
    logic             w_xfer;
    logic             w_last;
    logic [SW-1:0]    w_stall_next;
    logic [TW-1:0]    w_idle_next;
    logic             w_hit_timeout;

    // Select the expected word for the index about to be accepted
    always_comb begin
        w_exp = EXPECT_INIT[DW-1:0];
        for (int i = 0; i < SIZE; i++) begin
            if (r_count == CW'(i)) begin
                w_exp = EXPECT_INIT[i*DW +: DW];
            end
        end
    end

    // Per-lane difference in WIDTH+1 bits so the extreme case (e.g. 127 - -128) cannot overflow
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [WIDTH:0] w_diff;
        logic        [WIDTH:0] w_mag;
        assign w_diff = {iData_AM[k*WIDTH+WIDTH-1], iData_AM[k*WIDTH +: WIDTH]}
                      - {w_exp[k*WIDTH+WIDTH-1], w_exp[k*WIDTH +: WIDTH]};
        assign w_mag  = w_diff[WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);
        assign w_lane_bad[k] = (32'(w_mag) > 32'(TOLERANCE));
    end

    assign w_word_bad   = |w_lane_bad;
    assign w_xfer       = iValid_AM && r_ready;
    assign w_last       = (r_count == CW'(SIZE - 1));
    assign w_stall_next = (r_stall == SW'(STALL_PERIOD - 1)) ? '0 : r_stall + 1'b1;
    // A transfer clears idle, so the final transfer always wins over a coincident timeout
    assign w_idle_next  = w_xfer ? '0
                        : ((r_idle == TW'(TIMEOUT)) ? r_idle : r_idle + 1'b1);
    assign w_hit_timeout = (TIMEOUT != 0) && (w_idle_next == TW'(TIMEOUT));

    // Run/terminal state machine with registered ready, counters and verdict
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= S_RUN;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_tout  <= 1'b0;
            r_count <= '0;
            r_err   <= '0;
            r_first <= NONE;
            r_stall <= '0;
            r_idle  <= '0;
        end else if (r_state == S_RUN) begin
            r_stall <= w_stall_next;
            r_idle  <= w_idle_next;
            r_ready <= THROTTLE ? (w_stall_next == SW'(STALL_PERIOD - 1)) : 1'b1;
            if (w_xfer) begin
                r_count <= r_count + 1'b1;
                if (w_word_bad) begin
                    r_err <= r_err + 1'b1;
                    if (r_first == NONE) begin
                        r_first <= r_count;
                    end
                end
                if (w_last) begin
                    r_state <= S_DONE;
                    r_ready <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (r_err == '0) && !w_word_bad;
                end
            end else if (w_hit_timeout) begin
                r_state <= S_TOUT;
                r_ready <= 1'b0;
                r_done  <= 1'b1;
                r_tout  <= 1'b1;
            end
        end
    end

    assign oReady_AM = r_ready;
    assign oDone     = r_done;
    assign oPass     = r_pass;
    assign oTimeout  = r_tout;
    assign oCount    = r_count;
    assign oErrCount = r_err;
    assign oFirstErr = r_first;

endmodule
